// File: rtl/music_seq.sv
// music_seq -- programmable melody sequencer.
//
// Plays a list of {dur, note} entries from an internal writable melody
// memory, one step every P clock cycles. An entry lasts (dur+1) steps.
// Supports one-shot or looped playback, pause (level) and stop.
//
// Optional feature macro: MUSIC_SEQ_TEMPO_EN
//   defined   : adds input tempo_div[19:0]; P = tempo_div+1, sampled on
//               start and whenever the step counter wraps to 0.
//   undefined : P = TICK_DIV.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data  melody memory write port ({dur, note});
//                       addresses >= DEPTH are dropped
//   len                 number of entries to play, sampled on start
//   start, stop         restart from entry 0 / abort (stop wins)
//   pause, loop         level controls
//   tempo_div           step period minus one (MUSIC_SEQ_TEMPO_EN only)
//   note                registered current note code (0 = rest)
//   speak               speaker enable
//   busy                high while playing
//   done                one-cycle pulse at the natural end of a one-shot
//   pos                 index of the next entry to load
module music_seq #(
    parameter int NOTE_W   = 4,
    parameter int DUR_W    = 3,
    parameter int DEPTH    = 128,
    parameter int TICK_DIV = 625000,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DUR_W+NOTE_W-1:0]  wr_data,
    input  logic [AW:0]              len,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic                     loop,
`ifdef MUSIC_SEQ_TEMPO_EN
    input  logic [19:0]              tempo_div,
`endif
    output logic [NOTE_W-1:0]        note,
    output logic                     speak,
    output logic                     busy,
    output logic                     done,
    output logic [AW:0]              pos
);

`ifdef MUSIC_SEQ_TEMPO_EN
    localparam int CNT_W = 20;
`else
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`endif

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t                 state_q, state_d;
    logic [NOTE_W-1:0]      note_q, note_d;
    logic [DUR_W-1:0]       rem_q, rem_d;
    logic [AW:0]            pos_q, pos_d;
    logic [AW:0]            len_q, len_d;
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_max;

    // Melody memory: no reset so contents survive rst; combinational
    // read so a write landing on the loading edge is not yet visible.
    logic [DUR_W+NOTE_W-1:0] mem [DEPTH];
    logic [DUR_W+NOTE_W-1:0] entry_cur;
    logic [DUR_W+NOTE_W-1:0] entry_first;

    assign entry_cur   = mem[pos_q[AW-1:0]];
    assign entry_first = mem[0];

    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH))) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef MUSIC_SEQ_TEMPO_EN
    logic [19:0] pm1_q, pm1_d;   // current period minus one
    assign cnt_max = pm1_q;
`else
    assign cnt_max = CNT_W'(TICK_DIV - 1);
`endif

    logic play;
    logic wrap;
    assign play = (state_q == S_PLAY);
    assign wrap = (cnt_q == cnt_max);

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef MUSIC_SEQ_TEMPO_EN
        pm1_d   = pm1_q;
`endif
        if (stop) begin
            state_d = S_IDLE;
            note_d  = '0;
            pos_d   = '0;
            rem_d   = '0;
            cnt_d   = '0;
        end else if (start && (len != '0)) begin
            // cnt=0 makes the very next cycle a tick, so the first note
            // appears two cycles after start is sampled.
            state_d = S_PLAY;
            pos_d   = '0;
            rem_d   = '0;
            cnt_d   = '0;
            len_d   = len;
`ifdef MUSIC_SEQ_TEMPO_EN
            pm1_d   = tempo_div;
`endif
        end else if (play && !pause) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
`ifdef MUSIC_SEQ_TEMPO_EN
            if (wrap) begin
                pm1_d = tempo_div;
            end
`endif
            if (cnt_q == '0) begin
                if (rem_q != '0) begin
                    rem_d = rem_q - 1'b1;
                end else if (pos_q < len_q) begin
                    note_d = entry_cur[NOTE_W-1:0];
                    rem_d  = entry_cur[DUR_W+NOTE_W-1:NOTE_W];
                    pos_d  = pos_q + 1'b1;
                end else if (loop) begin
                    // Wrap loads entry 0 on this same tick: no gap.
                    note_d = entry_first[NOTE_W-1:0];
                    rem_d  = entry_first[DUR_W+NOTE_W-1:NOTE_W];
                    pos_d  = (AW+1)'(1);
                end else begin
                    // Natural end: pos keeps len so the host can see it.
                    note_d  = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            note_q  <= '0;
            rem_q   <= '0;
            pos_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef MUSIC_SEQ_TEMPO_EN
            pm1_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef MUSIC_SEQ_TEMPO_EN
            pm1_q   <= pm1_d;
`endif
        end
    end

    assign note  = note_q;
    assign busy  = play;
    assign done  = done_q;
    assign pos   = pos_q;
    // Pause mutes the speaker but leaves the note register untouched.
    assign speak = (note_q != '0) && play && !pause;

endmodule

// File: tb/tb_music_seq.sv
// Scoreboard bench for music_seq (DEPTH=6, step period 4 cycles).
// Expected output values are queued with the cycle they must appear in
// when each stimulus is issued; a monitor pops and compares them.
module tb_music_seq;
    localparam int NOTE_W   = 4;
    localparam int DUR_W    = 3;
    localparam int DEPTH    = 6;
    localparam int TICK_DIV = 4;
    localparam int AW       = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DUR_W+NOTE_W-1:0] wr_data = '0;
    logic [AW:0] len = '0;
    logic start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0;
`ifdef MUSIC_SEQ_TEMPO_EN
    logic [19:0] tempo_div = 20'd3;
`endif
    logic [NOTE_W-1:0] note;
    logic speak, busy, done;
    logic [AW:0] pos;

    music_seq #(
        .NOTE_W(NOTE_W), .DUR_W(DUR_W), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .stop(stop), .pause(pause), .loop(loop),
`ifdef MUSIC_SEQ_TEMPO_EN
        .tempo_div(tempo_div),
`endif
        .note(note), .speak(speak), .busy(busy), .done(done), .pos(pos)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        string tag;
        int    sel;   // 0 note, 1 speak, 2 busy, 3 done, 4 pos
        int    val;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic int obs_of(input int sel);
        case (sel)
            0: return int'(note);
            1: return int'(speak);
            2: return int'(busy);
            3: return int'(done);
            default: return int'(pos);
        endcase
    endfunction

    // Insert keeping the queue ordered by cycle.
    task automatic ex(input int c, input string tag, input int sel, input int val);
        exp_t e;
        int i;
        e = '{c, tag, sel, val};
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endtask

    // Monitor: samples 1 ns after the falling edge, where inputs driven
    // on that edge and async reset have settled.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) check({e.tag, "_missed"}, -1, e.val);
            else             check(e.tag, obs_of(e.sel), e.val);
        end
    end

    task automatic wait_cyc(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wr(input int a, input int d, input int n);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = (DUR_W+NOTE_W)'((d << NOTE_W) | n);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Drives start for one cycle; t is the cycle in which it is sampled.
    // Returns on the falling edge of cycle t+1.
    task automatic go(input int l, output int t);
        @(negedge clk);
        len   = (AW+1)'(l);
        start = 1'b1;
        t     = cyc;
        @(negedge clk);
        start = 1'b0;
        $display("[TB] start len=%0d at cyc %0d", l, t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ex(cyc+1, "rst_note", 0, 0);  ex(cyc+1, "rst_speak", 1, 0);
        ex(cyc+1, "rst_busy", 2, 0);  ex(cyc+1, "rst_done", 3, 0);
        ex(cyc+1, "rst_pos", 4, 0);

        wr(0, 0, 3); wr(1, 1, 8); wr(2, 0, 0);

        // One-shot
        go(3, t);
        ex(t+1, "os_busy", 2, 1);
        ex(t+2, "os_n3", 0, 3);      ex(t+2, "os_spk3", 1, 1);  ex(t+2, "os_pos1", 4, 1);
        ex(t+5, "os_n3_end", 0, 3);
        ex(t+6, "os_n8", 0, 8);      ex(t+6, "os_pos2", 4, 2);
        ex(t+13, "os_n8_end", 0, 8);
        ex(t+14, "os_n0", 0, 0);     ex(t+14, "os_spk0", 1, 0); ex(t+14, "os_pos3", 4, 3);
        ex(t+14, "os_busy14", 2, 1);
        ex(t+17, "os_nodone17", 3, 0); ex(t+17, "os_busy17", 2, 1);
        ex(t+18, "os_done", 3, 1);   ex(t+18, "os_idle", 2, 0);
        ex(t+18, "os_note_end", 0, 0); ex(t+18, "os_pos_end", 4, 3);
        ex(t+19, "os_done_pulse", 3, 0);
        wait_cyc(t+20);

        // Loop, then drop loop for one more pass
        loop = 1'b1;
        go(3, t);
        ex(t+14, "lp_n0", 0, 0);
        ex(t+17, "lp_busy17", 2, 1);
        ex(t+18, "lp_wrap_n3", 0, 3); ex(t+18, "lp_wrap_pos", 4, 1);
        ex(t+18, "lp_nodone", 3, 0);  ex(t+18, "lp_busy18", 2, 1);
        ex(t+22, "lp_n8", 0, 8);      ex(t+22, "lp_pos2", 4, 2);
        ex(t+30, "lp_n0b", 0, 0);
        ex(t+33, "lp_nodone33", 3, 0); ex(t+33, "lp_busy33", 2, 1);
        ex(t+34, "lp_done", 3, 1);    ex(t+34, "lp_idle", 2, 0);
        ex(t+35, "lp_done_pulse", 3, 0);
        wait_cyc(t+20);
        loop = 1'b0;
        wait_cyc(t+36);

        // Pause 7 cycles during note 8
        go(3, t);
        ex(t+6, "pz_n8", 0, 8);
        ex(t+7, "pz_mute", 1, 0);     ex(t+7, "pz_hold", 0, 8);  ex(t+7, "pz_busy", 2, 1);
        ex(t+13, "pz_mute13", 1, 0);  ex(t+13, "pz_hold13", 0, 8);
        ex(t+14, "pz_unmute", 1, 1);  ex(t+14, "pz_n8_14", 0, 8);
        ex(t+20, "pz_n8_ext", 0, 8);
        ex(t+21, "pz_n0", 0, 0);
        ex(t+24, "pz_nodone", 3, 0);  ex(t+24, "pz_busy24", 2, 1);
        ex(t+25, "pz_done", 3, 1);    ex(t+25, "pz_idle", 2, 0);
        wait_cyc(t+7);
        pause = 1'b1;
        wait_cyc(t+14);
        pause = 1'b0;
        wait_cyc(t+27);

        // Stop and start together: stop wins
        go(3, t);
        ex(t+6, "ss_n8", 0, 8);
        ex(t+7, "ss_idle", 2, 0);  ex(t+7, "ss_note0", 0, 0);
        ex(t+7, "ss_pos0", 4, 0);  ex(t+7, "ss_nodone", 3, 0);
        for (int k = 8; k <= 20; k += 4) begin
            ex(t+k, "ss_nodone_k", 3, 0);
            ex(t+k, "ss_idle_k", 2, 0);
        end
        wait_cyc(t+6);
        stop = 1'b1; start = 1'b1;
        wait_cyc(t+7);
        stop = 1'b0; start = 1'b0;
        wait_cyc(t+21);

        // start with len=0 is ignored
        go(0, t);
        ex(t+1, "l0_idle", 2, 0);
        ex(t+3, "l0_idle3", 2, 0); ex(t+3, "l0_note", 0, 0); ex(t+3, "l0_pos", 4, 0);
        wait_cyc(t+4);

        // Writes during playback: e0 written on its loading edge (old
        // data plays), e1 rewritten to {0,5} before it loads.
        go(3, t);
        wr_en = 1'b1; wr_addr = 0; wr_data = (DUR_W+NOTE_W)'(6);
        ex(t+2, "wp_old_n3", 0, 3);
        ex(t+6, "wp_new_n5", 0, 5);
        ex(t+10, "wp_n0", 0, 0);
        ex(t+14, "wp_done", 3, 1); ex(t+14, "wp_idle", 2, 0);
        wait_cyc(t+2);
        wr_addr = 1; wr_data = (DUR_W+NOTE_W)'(5);
        wait_cyc(t+3);
        wr_en = 1'b0;
        wait_cyc(t+16);

        // Reset mid-playback, then replay
        go(3, t);
        ex(t+2, "rm_n6", 0, 6);
        ex(t+5, "rm_n6b", 0, 6);
        wait_cyc(t+6);
        rst = 1'b1;
        ex(t+6, "rm_note", 0, 0);  ex(t+6, "rm_speak", 1, 0);
        ex(t+6, "rm_busy", 2, 0);  ex(t+6, "rm_pos", 4, 0);
        ex(t+6, "rm_done", 3, 0);
        wait_cyc(t+7);
        rst = 1'b0;
        ex(t+8, "rm_idle", 2, 0);
        wait_cyc(t+9);
        go(3, t);
        ex(t+2, "rr_n6", 0, 6);
        ex(t+6, "rr_n5", 0, 5);
        ex(t+10, "rr_n0", 0, 0);
        ex(t+14, "rr_done", 3, 1);
        wait_cyc(t+16);

        // Out-of-range writes ignored; play full DEPTH
        wr(6, 0, 7); wr(7, 0, 7);
        wr(3, 0, 1); wr(4, 0, 2); wr(5, 0, 4);
        go(6, t);
        ex(t+2, "dp_n6", 0, 6);
        ex(t+6, "dp_n5", 0, 5);
        ex(t+10, "dp_n0", 0, 0);
        ex(t+14, "dp_n1", 0, 1);
        ex(t+18, "dp_n2", 0, 2);
        ex(t+22, "dp_n4", 0, 4);   ex(t+22, "dp_spk", 1, 1);  ex(t+22, "dp_pos6", 4, 6);
        ex(t+25, "dp_n4_end", 0, 4);
        ex(t+26, "dp_note0", 0, 0); ex(t+26, "dp_done", 3, 1);
        ex(t+26, "dp_idle", 2, 0);  ex(t+26, "dp_pos_len", 4, 6);
        wait_cyc(t+28);

`ifdef MUSIC_SEQ_TEMPO_EN
        // tempo_div=0: one step per clock
        tempo_div = 20'd0;
        go(6, t);
        ex(t+2, "tp_n6", 0, 6);
        ex(t+3, "tp_n5", 0, 5);
        ex(t+4, "tp_n0", 0, 0);
        ex(t+5, "tp_n1", 0, 1);
        ex(t+6, "tp_n2", 0, 2);
        ex(t+7, "tp_n4", 0, 4);
        ex(t+8, "tp_done", 3, 1);  ex(t+8, "tp_idle", 2, 0);
        wait_cyc(t+10);
        tempo_div = 20'd3;
`endif

        wait_cyc(cyc + 3);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
